// File: rtl/blockram_arb_pkg.sv
// Shared types for the block-RAM burst arbiter: FSM states, grant identity
// and the depth of the read skid buffer.
package blockram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/blockram_rd_skid.sv
// Two-entry read-data buffer behind a 1-cycle-latency BRAM. Tracks the read in
// flight so that issue is throttled before the buffer could overflow.
module blockram_rd_skid
  import blockram_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_i,
  input  logic              issue_last_i,
  input  logic [DATA_W-1:0] bram_rdata_i,
  input  logic              pop_i,
  output logic              can_issue_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  logic              inflight_q;
  logic              inflight_last_q;
  logic [DATA_W-1:0] mem_data_q [SKID_DEPTH];
  logic              mem_last_q [SKID_DEPTH];
  logic              rptr_q;
  logic              wptr_q;
  logic [1:0]        count_q;

  logic empty;
  logic push;
  logic pop_mem;

  assign empty = (count_q == 2'd0);

  // When the buffer is empty the returning BRAM word is presented directly,
  // giving first data two cycles after the grant.
  assign valid_o     = !empty || inflight_q;
  assign data_o      = !valid_o ? '0 : (empty ? bram_rdata_i : mem_data_q[rptr_q]);
  assign last_o      = valid_o && (empty ? inflight_last_q : mem_last_q[rptr_q]);
  assign pop_mem     = pop_i && !empty;
  assign push        = inflight_q && !(empty && pop_i);
  assign can_issue_o = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'(SKID_DEPTH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rptr_q          <= 1'b0;
      wptr_q          <= 1'b0;
      count_q         <= 2'd0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
      end
    end else begin
      inflight_q      <= issue_i;
      inflight_last_q <= issue_i && issue_last_i;
      if (push) begin
        mem_data_q[wptr_q] <= bram_rdata_i;
        mem_last_q[wptr_q] <= inflight_last_q;
        wptr_q             <= ~wptr_q;
      end
      if (pop_mem) begin
        rptr_q <= ~rptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop_mem};
    end
  end

endmodule

// File: rtl/blockram_burst_arbiter.sv
// Burst-granular round-robin arbiter placing write and read bursts from two
// requesters onto one single-port BRAM, with per-beat address generation.
module blockram_burst_arbiter
  import blockram_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                wr_req_valid,
  output logic                wr_req_ready,
  input  logic [ADDR_W-1:0]   wr_req_addr,
  input  logic [LEN_W-1:0]    wr_req_len,
  input  logic                wr_data_valid,
  output logic                wr_data_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                wr_done,
  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [ADDR_W-1:0]   rd_req_addr,
  input  logic [LEN_W-1:0]    rd_req_len,
  output logic                rd_data_valid,
  input  logic                rd_data_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_wdata,
  input  logic [DATA_W-1:0]   bram_rdata,
  output state_t              dbg_state
);

  // Handshakes: a transfer happens in a cycle where valid && ready are both 1;
  // valid never waits on ready, and ready may depend combinationally on valid.

  state_t             state_q, state_d;
  grant_t             last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic               issue_done_q, issue_done_d;
  logic               wr_done_q, wr_done_d;

  logic               rd_issue;
  logic               rd_issue_last;
  logic               can_issue;
  logic               rd_pop;
  logic [ADDR_W-1:0]  beat_addr;

  assign beat_addr = base_q + ADDR_W'(beat_q);
  assign rd_pop    = rd_data_valid && rd_data_ready;
  assign wr_done   = wr_done_q;
  assign dbg_state = state_q;

  blockram_rd_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk_i        (ACLK),
    .rst_i        (ARESET),
    .issue_i      (rd_issue),
    .issue_last_i (rd_issue_last),
    .bram_rdata_i (bram_rdata),
    .pop_i        (rd_pop),
    .can_issue_o  (can_issue),
    .valid_o      (rd_data_valid),
    .data_o       (rd_data),
    .last_o       (rd_last)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    base_d        = base_q;
    len_d         = len_q;
    beat_d        = beat_q;
    issue_done_d  = issue_done_q;
    wr_done_d     = 1'b0;
    wr_req_ready  = 1'b0;
    rd_req_ready  = 1'b0;
    wr_data_ready = 1'b0;
    rd_issue      = 1'b0;
    rd_issue_last = 1'b0;
    bram_en       = 1'b0;
    bram_we       = '0;
    bram_addr     = '0;
    bram_wdata    = '0;
    unique case (state_q)
      IDLE: begin
        // Reset gates the combinational grant so every output reads 0 while held.
        if (!ARESET) begin
          if (wr_req_valid && (!rd_req_valid || last_grant_q == GNT_RD)) begin
            wr_req_ready = 1'b1;
            state_d      = WR_BURST;
            last_grant_d = GNT_WR;
            base_d       = wr_req_addr;
            len_d        = wr_req_len;
            beat_d       = '0;
          end else if (rd_req_valid) begin
            rd_req_ready = 1'b1;
            state_d      = RD_BURST;
            last_grant_d = GNT_RD;
            base_d       = rd_req_addr;
            len_d        = rd_req_len;
            beat_d       = '0;
            issue_done_d = 1'b0;
          end
        end
      end
      WR_BURST: begin
        wr_data_ready = 1'b1;
        if (wr_data_valid) begin
          bram_en    = 1'b1;
          bram_we    = wr_strb;
          bram_addr  = beat_addr;
          bram_wdata = wr_data;
          if (beat_q == len_q) begin
            state_d   = IDLE;
            wr_done_d = 1'b1;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      RD_BURST: begin
        if (!issue_done_q && can_issue) begin
          rd_issue      = 1'b1;
          rd_issue_last = (beat_q == len_q);
          bram_en       = 1'b1;
          bram_addr     = beat_addr;
          if (beat_q == len_q) begin
            issue_done_d = 1'b1;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
        if (rd_pop && rd_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_RD;
      base_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      issue_done_q <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      issue_done_q <= issue_done_d;
      wr_done_q    <= wr_done_d;
    end
  end

endmodule

// File: tb/tb_blockram_burst_arbiter.sv
// Directed bench for blockram_burst_arbiter: a burst vector table plus hand
// sequences for arbitration order and reset during a read burst.
module tb_blockram_burst_arbiter;
  import blockram_arb_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int STRB_W = DATA_W / 8;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic              wr_req_valid = 1'b0;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr = '0;
  logic [LEN_W-1:0]  wr_req_len = '0;
  logic              wr_data_valid = 1'b0;
  logic              wr_data_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic [STRB_W-1:0] wr_strb = '0;
  logic              wr_done;
  logic              rd_req_valid = 1'b0;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr = '0;
  logic [LEN_W-1:0]  rd_req_len = '0;
  logic              rd_data_valid;
  logic              rd_data_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              bram_en;
  logic [STRB_W-1:0] bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata = '0;
  state_t            dbg_state;

  int n_vec  = 0;
  int n_fail = 0;
  int wr_done_cnt = 0;

  blockram_burst_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_done(wr_done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 ACLK = ~ACLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, fails so far %0d", n_fail);
    $fatal(1);
  end

  // Single-port BRAM environment with byte enables and 1-cycle read latency
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;

  always @(posedge ACLK) begin
    if (bram_en) begin
      bram_rdata <= mem[bram_addr];
      for (int b = 0; b < STRB_W; b++)
        if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
    end
  end

  always @(negedge ACLK) if (wr_done) wr_done_cnt <= wr_done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] step;
    logic [STRB_W-1:0] strb;
    bit                toggle;
  } vec_t;

  function automatic vec_t mk(bit w, logic [ADDR_W-1:0] a, logic [LEN_W-1:0] l,
                              logic [DATA_W-1:0] d0, logic [DATA_W-1:0] st,
                              logic [STRB_W-1:0] sb, bit tg);
    vec_t v;
    v.is_wr = w; v.addr = a; v.len = l; v.d0 = d0; v.step = st; v.strb = sb; v.toggle = tg;
    return v;
  endfunction

  // Driver: one write burst, checking every beat on the BRAM port
  task automatic do_write(input vec_t v);
    bit got = 0;
    int c0;
    @(posedge ACLK); #1;
    wr_req_valid = 1'b1; wr_req_addr = v.addr; wr_req_len = v.len;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (wr_req_ready) begin got = 1; break; end
    end
    check("wr_grant", 32'(got), 32'd1);
    c0 = wr_done_cnt;
    @(posedge ACLK); #1;
    wr_req_valid = 1'b0;
    if (!got) return;
    for (int b = 0; b <= int'(v.len); b++) begin
      wr_data_valid = 1'b1;
      wr_data = v.d0 + v.step * DATA_W'(b);
      wr_strb = v.strb;
      @(negedge ACLK);
      check("wr_data_ready", 32'(wr_data_ready), 32'd1);
      check("wr_bram_en", 32'(bram_en), 32'd1);
      check("wr_bram_we", 32'(bram_we), 32'(v.strb));
      check("wr_bram_addr", 32'(bram_addr), 32'(ADDR_W'(v.addr + ADDR_W'(b))));
      check("wr_bram_wdata", bram_wdata, v.d0 + v.step * DATA_W'(b));
      @(posedge ACLK); #1;
    end
    wr_data_valid = 1'b0;
    @(negedge ACLK);
    check("wr_done_pulse", 32'(wr_done), 32'd1);
    check("wr_back_idle", 32'(dbg_state), 32'(IDLE));
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    check("wr_done_count", 32'(wr_done_cnt - c0), 32'd1);
  endtask

  // Driver: one read burst; abort_after > 0 returns right after that many beats
  task automatic do_read(input vec_t v, input int abort_after);
    bit got = 0;
    bit done = 0;
    int issued = 0, popped = 0, max_out = 0, first_en = -1, first_vld = -1;
    @(posedge ACLK); #1;
    rd_req_valid = 1'b1; rd_req_addr = v.addr; rd_req_len = v.len; rd_data_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (rd_req_ready) begin got = 1; break; end
    end
    check("rd_grant", 32'(got), 32'd1);
    @(posedge ACLK); #1;
    rd_req_valid = 1'b0;
    if (!got) return;
    rd_data_ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge ACLK);
      if (bram_en) begin
        if (first_en < 0) first_en = cyc;
        check("rd_bram_addr", 32'(bram_addr), 32'(ADDR_W'(v.addr + ADDR_W'(issued))));
        check("rd_bram_we", 32'(bram_we), 32'd0);
        issued++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (rd_data_valid && first_vld < 0) first_vld = cyc;
      if (rd_data_valid && rd_data_ready) begin
        check("rd_data", rd_data, v.d0 + v.step * DATA_W'(popped));
        check("rd_last", 32'(rd_last), 32'(popped == int'(v.len)));
        popped++;
      end
      if (popped == int'(v.len) + 1) begin done = 1; break; end
      if (abort_after > 0 && popped == abort_after) return;
      @(posedge ACLK); #1;
      if (v.toggle) rd_data_ready = ~rd_data_ready;
    end
    check("rd_complete", 32'(done), 32'd1);
    check("rd_issue_count", 32'(issued), 32'(int'(v.len) + 1));
    check("rd_max_outstanding_le2", 32'(max_out <= 2), 32'd1);
    check("rd_first_en_latency", 32'(first_en), 32'd0);
    check("rd_first_valid_latency", 32'(first_vld), 32'd1);
    @(posedge ACLK); #1;
    rd_data_ready = 1'b0;
    @(negedge ACLK);
    check("rd_back_idle", 32'(dbg_state), 32'(IDLE));
    check("rd_valid_clear", 32'(rd_data_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {25'd0, wr_req_ready, rd_req_ready, wr_data_ready, wr_done,
                            rd_data_valid, rd_last, bram_en}, 32'd0);
    check({tag, "_bram_we"}, 32'(bram_we), 32'd0);
    check({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
    check({tag, "_bram_wdata"}, bram_wdata, 32'd0);
    check({tag, "_rd_data"}, rd_data, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = mk(1, 10'h3FE, 8'd3, 32'h0000_0100, 32'd1, 4'hF, 0);
    vecs[1] = mk(0, 10'h3FE, 8'd3, 32'h0000_0100, 32'd1, 4'h0, 0);
    vecs[2] = mk(1, 10'h000, 8'd7, 32'h0000_0001, 32'd1, 4'hF, 0);
    vecs[3] = mk(0, 10'h000, 8'd7, 32'h0000_0001, 32'd1, 4'h0, 0);
    vecs[4] = mk(1, 10'h020, 8'd0, 32'h1122_3344, 32'd1, 4'hF, 0);
    vecs[5] = mk(1, 10'h020, 8'd0, 32'hAABB_CCDD, 32'd1, 4'h3, 0);
    vecs[6] = mk(0, 10'h020, 8'd0, 32'h1122_CCDD, 32'd0, 4'h0, 0);
    vecs[7] = mk(1, 10'h030, 8'd1, 32'h0000_0055, 32'd1, 4'h0, 0);
    vecs[8] = mk(0, 10'h030, 8'd1, 32'h0000_0000, 32'd0, 4'h0, 0);
    vecs[9] = mk(0, 10'h000, 8'd3, 32'h0000_0001, 32'd1, 4'h0, 1);

    // Reset state, including a request presented while reset is held
    repeat (2) @(posedge ACLK);
    #1 wr_req_valid = 1'b1;
    @(negedge ACLK);
    check_all_zero("reset");
    wr_req_valid = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;

    // Contested grants: write first after reset, then read
    @(posedge ACLK); #1;
    wr_req_valid = 1'b1; wr_req_addr = 10'h040; wr_req_len = 8'd0;
    rd_req_valid = 1'b1; rd_req_addr = 10'h040; rd_req_len = 8'd0;
    @(negedge ACLK);
    check("arb1_wr_ready", 32'(wr_req_ready), 32'd1);
    check("arb1_rd_ready", 32'(rd_req_ready), 32'd0);
    @(posedge ACLK); #1;
    wr_req_valid = 1'b0;
    wr_data_valid = 1'b1; wr_data = 32'hCAFE_0001; wr_strb = 4'hF;
    @(negedge ACLK);
    check("arb_rd_held_off", 32'(rd_req_ready), 32'd0);
    check("arb_wr_state", 32'(dbg_state), 32'(WR_BURST));
    check("arb_wr_en", 32'(bram_en), 32'd1);
    @(posedge ACLK); #1;
    wr_data_valid = 1'b0;
    wr_req_valid = 1'b1; wr_req_addr = 10'h050;
    @(negedge ACLK);
    check("arb2_wr_done", 32'(wr_done), 32'd1);
    check("arb2_rd_ready", 32'(rd_req_ready), 32'd1);
    check("arb2_wr_ready", 32'(wr_req_ready), 32'd0);
    @(posedge ACLK); #1;
    wr_req_valid = 1'b0; rd_req_valid = 1'b0; rd_data_ready = 1'b1;
    @(negedge ACLK);
    check("arb_rd_en", 32'(bram_en), 32'd1);
    check("arb_rd_addr", 32'(bram_addr), 32'h40);
    @(negedge ACLK);
    check("arb_rd_valid", 32'(rd_data_valid), 32'd1);
    check("arb_rd_data", rd_data, 32'hCAFE_0001);
    check("arb_rd_last", 32'(rd_last), 32'd1);
    @(posedge ACLK); #1;
    rd_data_ready = 1'b0;
    @(negedge ACLK);
    check("arb_idle", 32'(dbg_state), 32'(IDLE));

    // Vector table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i]);
      else               do_read(vecs[i], 0);
    end

    // Reset during beat 3 of an 8-beat read
    do_read(vecs[3], 3);
    #1 ARESET = 1'b1;
    #1;
    check_all_zero("abort");
    rd_data_ready = 1'b0;
    repeat (2) begin
      @(negedge ACLK);
      check("abort_no_en", 32'(bram_en), 32'd0);
      check("abort_no_done", 32'(wr_done), 32'd0);
    end
    ARESET = 1'b0;
    do_read(vecs[3], 0);
    do_write(mk(1, 10'h060, 8'd1, 32'h0000_0A00, 32'd1, 4'hF, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
